// File: rtl/cu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : cu_pkg                                                        |
// | Purpose  : Shared states, opcodes, ALU/bus select codes and flag indices |
// |            for the control_unit sequencer.                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cu_pkg;

  typedef enum logic [4:0] {
    S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3, S_WAIT,
    S_OPR_MAR, S_OPR_INC, S_LD_A, S_LD_B, S_DIR_MAR, S_DIR_IDLE,
    S_ST_A, S_ST_B, S_ADD, S_SUB, S_AND, S_OR,
    S_INCA, S_INCB, S_DECA, S_DECB,
    S_BR_MAR, S_BR_IDLE, S_BR_LOAD, S_BR_SKIP
  } state_t;

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_INCB    = 8'h47;
  localparam logic [7:0] OP_DECA    = 8'h48;
  localparam logic [7:0] OP_DECB    = 8'h49;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BPL     = 8'h22;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BNE     = 8'h24;
  localparam logic [7:0] OP_BVS     = 8'h25;
  localparam logic [7:0] OP_BVC     = 8'h26;
  localparam logic [7:0] OP_BCS     = 8'h27;
  localparam logic [7:0] OP_BCC     = 8'h28;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_INC = 3'b100;
  localparam logic [2:0] ALU_DEC = 3'b101;

  localparam logic [1:0] B1_PC   = 2'b00;
  localparam logic [1:0] B1_A    = 2'b01;
  localparam logic [1:0] B1_B    = 2'b10;
  localparam logic [1:0] B2_ALU  = 2'b00;
  localparam logic [1:0] B2_BUS1 = 2'b01;
  localparam logic [1:0] B2_MEM  = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: control_unit_if                                               |
// | Purpose  : Strobe/select bundle between control_unit and data_path.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface control_unit_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] IR;
  logic [3:0]        CCR_Result;
  logic              IR_Load;
  logic              MAR_Load;
  logic              PC_Load;
  logic              PC_Inc;
  logic              A_Load;
  logic              B_Load;
  logic              CCR_Load;
  logic [2:0]        ALU_Sel;
  logic [1:0]        Bus1_Sel;
  logic [1:0]        Bus2_Sel;
  logic              write;

  // Sequencer side
  modport master (
    input  IR, CCR_Result,
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
           ALU_Sel, Bus1_Sel, Bus2_Sel, write
  );

  // Data path / memory side
  modport slave (
    output IR, CCR_Result,
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
           ALU_Sel, Bus1_Sel, Bus2_Sel, write
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_branch_eval.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cu_branch_eval                                                |
// | Purpose  : Combinational branch decision from opcode and {N,Z,V,C}.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cu_branch_eval
  import cu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [3:0]        ccr,
  output logic              taken
);

  // Non-branch opcodes report not-taken
  always_comb begin
    taken = 1'b0;
    case (ir)
      DATA_W'(OP_BRA): taken = 1'b1;
      DATA_W'(OP_BMI): taken =  ccr[FLAG_N];
      DATA_W'(OP_BPL): taken = ~ccr[FLAG_N];
      DATA_W'(OP_BEQ): taken =  ccr[FLAG_Z];
      DATA_W'(OP_BNE): taken = ~ccr[FLAG_Z];
      DATA_W'(OP_BVS): taken =  ccr[FLAG_V];
      DATA_W'(OP_BVC): taken = ~ccr[FLAG_V];
      DATA_W'(OP_BCS): taken =  ccr[FLAG_C];
      DATA_W'(OP_BCC): taken = ~ccr[FLAG_C];
      default:         taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_unit                                                  |
// | Purpose  : Moore FSM sequencing fetch/decode/execute of the 8-bit        |
// |            data_path. Optional INCA/INCB/DECA/DECB via CU_INC_DEC_EN.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module control_unit
  import cu_pkg::*;
#(
  parameter int RD_WAIT = 1,
  parameter int DATA_W  = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  control_unit_if.master bus
);

  // Last counter value of a wait run; unused when RD_WAIT==1
  localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT - 2);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [2:0] cnt_q, cnt_d;
  logic       br_taken;
  logic       read_go;
  state_t     read_tgt;

  logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, wr;
  logic [2:0] alu_sel;
  logic [1:0] bus1_sel, bus2_sel;

  cu_branch_eval #(.DATA_W(DATA_W)) u_branch_eval (
    .ir    (bus.IR),
    .ccr   (bus.CCR_Result),
    .taken (br_taken)
  );

  // State, wait counter and post-wait return state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH_0;
      ret_q   <= S_FETCH_0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; read_go marks the cycle after which memory wait states apply
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    read_go  = 1'b0;
    read_tgt = S_FETCH_0;
    case (state_q)
      S_FETCH_0:  state_d = S_FETCH_1;
      S_FETCH_1:  begin read_go = 1'b1; read_tgt = S_FETCH_2; end
      S_FETCH_2:  state_d = S_DECODE_3;
      S_DECODE_3: begin
        state_d = S_FETCH_0;
        case (bus.IR)
          DATA_W'(OP_LDA_IMM), DATA_W'(OP_LDB_IMM),
          DATA_W'(OP_LDA_DIR), DATA_W'(OP_LDB_DIR),
          DATA_W'(OP_STA_DIR), DATA_W'(OP_STB_DIR): state_d = S_OPR_MAR;
          DATA_W'(OP_ADD_AB): state_d = S_ADD;
          DATA_W'(OP_SUB_AB): state_d = S_SUB;
          DATA_W'(OP_AND_AB): state_d = S_AND;
          DATA_W'(OP_OR_AB):  state_d = S_OR;
          DATA_W'(OP_BRA), DATA_W'(OP_BMI), DATA_W'(OP_BPL),
          DATA_W'(OP_BEQ), DATA_W'(OP_BNE), DATA_W'(OP_BVS),
          DATA_W'(OP_BVC), DATA_W'(OP_BCS), DATA_W'(OP_BCC):
            state_d = br_taken ? S_BR_MAR : S_BR_SKIP;
`ifdef CU_INC_DEC_EN
          DATA_W'(OP_INCA): state_d = S_INCA;
          DATA_W'(OP_INCB): state_d = S_INCB;
          DATA_W'(OP_DECA): state_d = S_DECA;
          DATA_W'(OP_DECB): state_d = S_DECB;
`endif
          default: state_d = S_FETCH_0;
        endcase
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ret_q;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_OPR_MAR: state_d = S_OPR_INC;
      S_OPR_INC: begin
        read_go = 1'b1;
        if (bus.IR == DATA_W'(OP_LDA_IMM))      read_tgt = S_LD_A;
        else if (bus.IR == DATA_W'(OP_LDB_IMM)) read_tgt = S_LD_B;
        else                                    read_tgt = S_DIR_MAR;
      end
      S_DIR_MAR: begin
        if (bus.IR == DATA_W'(OP_STA_DIR))      state_d = S_ST_A;
        else if (bus.IR == DATA_W'(OP_STB_DIR)) state_d = S_ST_B;
        else                                    state_d = S_DIR_IDLE;
      end
      S_DIR_IDLE: begin
        read_go  = 1'b1;
        read_tgt = (bus.IR == DATA_W'(OP_LDB_DIR)) ? S_LD_B : S_LD_A;
      end
      S_BR_MAR:  state_d = S_BR_IDLE;
      S_BR_IDLE: begin read_go = 1'b1; read_tgt = S_BR_LOAD; end
      default:   state_d = S_FETCH_0;
    endcase
    if (read_go) begin
      if (RD_WAIT > 1) begin
        state_d = S_WAIT;
        ret_d   = read_tgt;
      end else begin
        state_d = read_tgt;
      end
    end
  end

  // Moore output decode; everything not listed stays 0
  always_comb begin
    ir_load  = 1'b0;
    mar_load = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    a_load   = 1'b0;
    b_load   = 1'b0;
    ccr_load = 1'b0;
    wr       = 1'b0;
    alu_sel  = ALU_ADD;
    bus1_sel = B1_PC;
    bus2_sel = B2_ALU;
    case (state_q)
      S_FETCH_0, S_OPR_MAR, S_BR_MAR: begin
        bus1_sel = B1_PC; bus2_sel = B2_BUS1; mar_load = 1'b1;
      end
      S_FETCH_1, S_OPR_INC, S_BR_SKIP: pc_inc = 1'b1;
      S_FETCH_2: begin bus2_sel = B2_MEM; ir_load  = 1'b1; end
      S_LD_A:    begin bus2_sel = B2_MEM; a_load   = 1'b1; end
      S_LD_B:    begin bus2_sel = B2_MEM; b_load   = 1'b1; end
      S_DIR_MAR: begin bus2_sel = B2_MEM; mar_load = 1'b1; end
      S_BR_LOAD: begin bus2_sel = B2_MEM; pc_load  = 1'b1; end
      S_ST_A:    begin bus1_sel = B1_A;   wr       = 1'b1; end
      S_ST_B:    begin bus1_sel = B1_B;   wr       = 1'b1; end
      S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA: begin
        bus1_sel = B1_A; bus2_sel = B2_ALU; a_load = 1'b1; ccr_load = 1'b1;
        case (state_q)
          S_SUB:   alu_sel = ALU_SUB;
          S_AND:   alu_sel = ALU_AND;
          S_OR:    alu_sel = ALU_OR;
          S_INCA:  alu_sel = ALU_INC;
          S_DECA:  alu_sel = ALU_DEC;
          default: alu_sel = ALU_ADD;
        endcase
      end
      S_INCB, S_DECB: begin
        bus1_sel = B1_B; bus2_sel = B2_ALU; b_load = 1'b1; ccr_load = 1'b1;
        alu_sel  = (state_q == S_INCB) ? ALU_INC : ALU_DEC;
      end
      default: ;
    endcase
  end

  // Reset low forces every output to 0 immediately, including write
  assign bus.IR_Load  = ir_load  & Reset;
  assign bus.MAR_Load = mar_load & Reset;
  assign bus.PC_Load  = pc_load  & Reset;
  assign bus.PC_Inc   = pc_inc   & Reset;
  assign bus.A_Load   = a_load   & Reset;
  assign bus.B_Load   = b_load   & Reset;
  assign bus.CCR_Load = ccr_load & Reset;
  assign bus.write    = wr       & Reset;
  assign bus.ALU_Sel  = alu_sel  & {3{Reset}};
  assign bus.Bus1_Sel = bus1_sel & {2{Reset}};
  assign bus.Bus2_Sel = bus2_sel & {2{Reset}};

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_control_unit                                               |
// | Purpose  : Directed self-checking bench; two DUTs (RD_WAIT=1 and 3) each |
// |            driving a behavioural data_path + program memory.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] prog [2][256];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dp
    localparam int RW = (k == 0) ? 1 : 3;

    control_unit_if #(.DATA_W(8)) bus ();

    logic [7:0]  pc, mar, ir, a, b, bus1, bus2, alu;
    logic [3:0]  ccr;
    logic [8:0]  sum;
    logic        alu_v;
    logic [7:0]  wr_addr, wr_data;
    logic [14:0] outs;
    int          wr_total = 0;
    int          viol = 0;

    control_unit #(.RD_WAIT(RW), .DATA_W(8)) u_dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (bus)
    );

    assign bus.IR         = ir;
    assign bus.CCR_Result = ccr;
    assign outs = {bus.IR_Load, bus.MAR_Load, bus.PC_Load, bus.PC_Inc, bus.A_Load,
                   bus.B_Load, bus.CCR_Load, bus.ALU_Sel, bus.Bus1_Sel, bus.Bus2_Sel,
                   bus.write};

    // Bus muxes and ALU of the data_path
    always_comb begin
      case (bus.Bus1_Sel)
        2'b00:   bus1 = pc;
        2'b01:   bus1 = a;
        2'b10:   bus1 = b;
        default: bus1 = 8'h00;
      endcase
      sum   = 9'd0;
      alu_v = 1'b0;
      case (bus.ALU_Sel)
        3'b000: begin sum = {1'b0, bus1} + {1'b0, b}; alu_v = (bus1[7] == b[7]) && (sum[7] != bus1[7]); end
        3'b001: begin sum = {1'b0, bus1} - {1'b0, b}; alu_v = (bus1[7] != b[7]) && (sum[7] != bus1[7]); end
        3'b010: sum = {1'b0, bus1 & b};
        3'b011: sum = {1'b0, bus1 | b};
        3'b100: begin sum = {1'b0, bus1} + 9'd1; alu_v = (bus1 == 8'h7F); end
        3'b101: begin sum = {1'b0, bus1} - 9'd1; alu_v = (bus1 == 8'h80); end
        default: sum = 9'd0;
      endcase
      alu = sum[7:0];
      case (bus.Bus2_Sel)
        2'b00:   bus2 = alu;
        2'b01:   bus2 = bus1;
        2'b10:   bus2 = prog[k][mar];
        default: bus2 = 8'h00;
      endcase
    end

    // Data_path registers, store capture and strobe-exclusivity tally
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc <= 8'h00; mar <= 8'h00; ir <= 8'h00; a <= 8'h00; b <= 8'h00; ccr <= 4'h0;
      end else begin
        if (bus.IR_Load)  ir  <= bus2;
        if (bus.MAR_Load) mar <= bus2;
        if (bus.A_Load)   a   <= bus2;
        if (bus.B_Load)   b   <= bus2;
        if (bus.PC_Load)     pc <= bus2;
        else if (bus.PC_Inc) pc <= pc + 8'd1;
        if (bus.CCR_Load) ccr <= {alu[7], alu == 8'h00, alu_v, sum[8]};
        if (bus.write) begin
          wr_total <= wr_total + 1;
          wr_addr  <= mar;
          wr_data  <= bus1;
        end
        if ((bus.PC_Load && bus.PC_Inc) ||
            (bus.write && (bus.IR_Load || bus.MAR_Load || bus.PC_Load ||
                           bus.A_Load || bus.B_Load || bus.CCR_Load)))
          viol <= viol + 1;
      end
    end
  end

  localparam logic [14:0] O_F0    = {7'b0100000, 3'b000, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] O_INC   = {7'b0001000, 3'b000, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] O_IRLD  = {7'b1000000, 3'b000, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] O_MARM  = {7'b0100000, 3'b000, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] O_LDA   = {7'b0000100, 3'b000, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] O_PCLD  = {7'b0010000, 3'b000, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] O_STA   = {7'b0000000, 3'b000, 2'b01, 2'b00, 1'b1};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset, wipe both program memories
  task automatic prep();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      prog[0][i] = 8'h00;
      prog[1][i] = 8'h00;
    end
    @(negedge clk);
  endtask

  task automatic go();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    prep();
    prog[0][0] = 8'h86; prog[0][1] = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (g_dp[0].outs !== 15'd0) begin
        errors++; $display("FAIL reset_outs cyc%0d: got %h want 0000", c, g_dp[0].outs);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (g_dp[0].outs !== O_F0) begin
      errors++; $display("FAIL reset_release_f0: got %h want %h", g_dp[0].outs, O_F0);
    end
    checks++;
    if (g_dp[1].outs !== O_F0) begin
      errors++; $display("FAIL reset_release_f0_rw3: got %h want %h", g_dp[1].outs, O_F0);
    end
  endtask

  // Continues directly from test_reset: 0x86 0xAA already loaded
  task automatic test_lda_imm();
    tick(6);
    checks++;
    if (g_dp[0].a !== 8'h00) begin
      errors++; $display("FAIL lda_imm_early: got A=%h want 00", g_dp[0].a);
    end
    tick(1);
    checks++;
    if (g_dp[0].a !== 8'hAA || g_dp[0].pc !== 8'h02) begin
      errors++; $display("FAIL lda_imm: got A=%h PC=%h want A=aa PC=02", g_dp[0].a, g_dp[0].pc);
    end
    checks++;
    if (g_dp[0].outs !== O_F0) begin
      errors++; $display("FAIL lda_imm_back_f0: got %h want %h", g_dp[0].outs, O_F0);
    end
  endtask

  task automatic test_alu_store();
    int w0;
    prep();
    prog[0][0] = 8'h86; prog[0][1] = 8'h10; prog[0][2] = 8'h88; prog[0][3] = 8'h11;
    prog[0][4] = 8'h42; prog[0][5] = 8'h96; prog[0][6] = 8'hE0;
    w0 = g_dp[0].wr_total;
    go();
    tick(19);
    checks++;
    if (g_dp[0].a !== 8'h21 || g_dp[0].b !== 8'h11 || g_dp[0].ccr !== 4'b0000) begin
      errors++; $display("FAIL add_ab: got A=%h B=%h CCR=%b want A=21 B=11 CCR=0000",
                         g_dp[0].a, g_dp[0].b, g_dp[0].ccr);
    end
    tick(7);
    checks++;
    if (g_dp[0].outs !== O_STA) begin
      errors++; $display("FAIL sta_outs: got %h want %h", g_dp[0].outs, O_STA);
    end
    tick(1);
    checks++;
    if (g_dp[0].wr_addr !== 8'hE0 || g_dp[0].wr_data !== 8'h21) begin
      errors++; $display("FAIL sta_write: got addr=%h data=%h want addr=e0 data=21",
                         g_dp[0].wr_addr, g_dp[0].wr_data);
    end
    tick(5);
    checks++;
    if (g_dp[0].wr_total - w0 !== 1) begin
      errors++; $display("FAIL sta_write_count: got %0d want 1", g_dp[0].wr_total - w0);
    end
  endtask

  task automatic test_beq_taken();
    prep();
    prog[0][0] = 8'h86; prog[0][1] = 8'h05; prog[0][2] = 8'h88; prog[0][3] = 8'h05;
    prog[0][4] = 8'h43; prog[0][5] = 8'h23; prog[0][6] = 8'h40;
    go();
    tick(19);
    checks++;
    if (g_dp[0].a !== 8'h00 || g_dp[0].ccr !== 4'b0100) begin
      errors++; $display("FAIL sub_zero: got A=%h CCR=%b want A=00 CCR=0100", g_dp[0].a, g_dp[0].ccr);
    end
    tick(7);
    checks++;
    if (g_dp[0].pc !== 8'h40) begin
      errors++; $display("FAIL beq_taken: got PC=%h want 40", g_dp[0].pc);
    end
  endtask

  task automatic test_beq_not_taken();
    prep();
    prog[0][0] = 8'h86; prog[0][1] = 8'h05; prog[0][2] = 8'h88; prog[0][3] = 8'h06;
    prog[0][4] = 8'h43; prog[0][5] = 8'h23; prog[0][6] = 8'h40;
    go();
    tick(19);
    checks++;
    if (g_dp[0].a !== 8'hFF || g_dp[0].ccr !== 4'b1001) begin
      errors++; $display("FAIL sub_neg: got A=%h CCR=%b want A=ff CCR=1001", g_dp[0].a, g_dp[0].ccr);
    end
    tick(4);
    checks++;
    if (g_dp[0].outs !== O_INC) begin
      errors++; $display("FAIL beq_skip_outs: got %h want %h", g_dp[0].outs, O_INC);
    end
    tick(1);
    checks++;
    if (g_dp[0].pc !== 8'h07 || g_dp[0].outs !== O_F0) begin
      errors++; $display("FAIL beq_not_taken: got PC=%h outs=%h want PC=07 outs=%h",
                         g_dp[0].pc, g_dp[0].outs, O_F0);
    end
  endtask

  task automatic test_bra();
    prep();
    prog[0][0] = 8'h20; prog[0][1] = 8'h30;
    go();
    tick(6);
    checks++;
    if (g_dp[0].outs !== O_PCLD) begin
      errors++; $display("FAIL bra_pcload_outs: got %h want %h", g_dp[0].outs, O_PCLD);
    end
    tick(1);
    checks++;
    if (g_dp[0].pc !== 8'h30) begin
      errors++; $display("FAIL bra: got PC=%h want 30", g_dp[0].pc);
    end
  endtask

  task automatic test_rd_wait3();
    prep();
    prog[1][0] = 8'h87; prog[1][1] = 8'h80; prog[1][8'h80] = 8'h5C;
    go();
    tick(2);
    checks++;
    if (g_dp[1].outs !== 15'd0) begin
      errors++; $display("FAIL rw3_fetch_idle: got %h want 0000", g_dp[1].outs);
    end
    tick(2);
    checks++;
    if (g_dp[1].outs !== O_IRLD) begin
      errors++; $display("FAIL rw3_ir_load: got %h want %h", g_dp[1].outs, O_IRLD);
    end
    tick(6);
    checks++;
    if (g_dp[1].outs !== O_MARM) begin
      errors++; $display("FAIL rw3_dir_mar: got %h want %h", g_dp[1].outs, O_MARM);
    end
    tick(2);
    checks++;
    if (g_dp[1].outs !== 15'd0) begin
      errors++; $display("FAIL rw3_opr_idle: got %h want 0000", g_dp[1].outs);
    end
    tick(2);
    checks++;
    if (g_dp[1].a !== 8'h00 || g_dp[1].outs !== O_LDA) begin
      errors++; $display("FAIL rw3_lda_cycle: got A=%h outs=%h want A=00 outs=%h",
                         g_dp[1].a, g_dp[1].outs, O_LDA);
    end
    tick(1);
    checks++;
    if (g_dp[1].a !== 8'h5C || g_dp[1].pc !== 8'h02) begin
      errors++; $display("FAIL rw3_lda_dir: got A=%h PC=%h want A=5c PC=02", g_dp[1].a, g_dp[1].pc);
    end
  endtask

  task automatic test_reset_mid_store();
    int w0;
    prep();
    prog[0][0] = 8'h96; prog[0][1] = 8'hE0;
    w0 = g_dp[0].wr_total;
    go();
    tick(6);
    checks++;
    if (g_dp[0].outs !== O_MARM) begin
      errors++; $display("FAIL sta_mar_cycle: got %h want %h", g_dp[0].outs, O_MARM);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (g_dp[0].outs !== 15'd0) begin
      errors++; $display("FAIL abort_outs: got %h want 0000", g_dp[0].outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (g_dp[0].outs !== O_F0) begin
      errors++; $display("FAIL abort_f0: got %h want %h", g_dp[0].outs, O_F0);
    end
    tick(3);
    checks++;
    if (g_dp[0].wr_total - w0 !== 0) begin
      errors++; $display("FAIL abort_no_write: got %0d writes want 0", g_dp[0].wr_total - w0);
    end
    // Reset dropped while write is high must kill it combinationally
    prep();
    prog[0][0] = 8'h96; prog[0][1] = 8'hE0;
    go();
    tick(7);
    checks++;
    if (g_dp[0].outs !== O_STA) begin
      errors++; $display("FAIL st_cycle: got %h want %h", g_dp[0].outs, O_STA);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (g_dp[0].outs[0] !== 1'b0) begin
      errors++; $display("FAIL write_gated: got write=%b want 0", g_dp[0].outs[0]);
    end
  endtask

  task automatic test_unknown_op();
    prep();
    prog[0][0] = 8'h86; prog[0][1] = 8'h33; prog[0][2] = 8'hFF;
    go();
    tick(11);
    checks++;
    if (g_dp[0].a !== 8'h33 || g_dp[0].b !== 8'h00 || g_dp[0].ccr !== 4'h0 ||
        g_dp[0].pc !== 8'h03 || g_dp[0].outs !== O_F0) begin
      errors++; $display("FAIL nop_ff: got A=%h B=%h CCR=%b PC=%h outs=%h want 33 00 0000 03 %h",
                         g_dp[0].a, g_dp[0].b, g_dp[0].ccr, g_dp[0].pc, g_dp[0].outs, O_F0);
    end
  endtask

  task automatic test_inc_dec();
    prep();
`ifdef CU_INC_DEC_EN
    prog[0][0] = 8'h86; prog[0][1] = 8'hFF; prog[0][2] = 8'h46;
    go();
    tick(12);
    checks++;
    if (g_dp[0].a !== 8'h00 || g_dp[0].ccr !== 4'b0101) begin
      errors++; $display("FAIL inca: got A=%h CCR=%b want A=00 CCR=0101", g_dp[0].a, g_dp[0].ccr);
    end
`else
    prog[0][0] = 8'h86; prog[0][1] = 8'h33; prog[0][2] = 8'h46;
    go();
    tick(11);
    checks++;
    if (g_dp[0].a !== 8'h33 || g_dp[0].ccr !== 4'h0 || g_dp[0].outs !== O_F0) begin
      errors++; $display("FAIL nop_46: got A=%h CCR=%b outs=%h want 33 0000 %h",
                         g_dp[0].a, g_dp[0].ccr, g_dp[0].outs, O_F0);
    end
`endif
  endtask

  task automatic test_invariants();
    checks++;
    if (g_dp[0].viol !== 0 || g_dp[1].viol !== 0) begin
      errors++; $display("FAIL strobe_exclusive: got %0d/%0d violations want 0/0",
                         g_dp[0].viol, g_dp[1].viol);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_lda_imm();
    test_alu_store();
    test_beq_taken();
    test_beq_not_taken();
    test_bra();
    test_rd_wait3();
    test_reset_mid_store();
    test_unknown_op();
    test_inc_dec();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
